// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive path.
// FSM encoding, oversample phases and a parameter legality check.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  localparam int OS_RATE = 16;
  localparam int OS_W    = $clog2(OS_RATE);

  localparam logic [OS_W-1:0] OS_MID_LO = OS_W'(7);
  localparam logic [OS_W-1:0] OS_MID    = OS_W'(8);
  localparam logic [OS_W-1:0] OS_MID_HI = OS_W'(9);

  function automatic bit params_ok(
    input int div,
    input int dbits,
    input int sbits,
    input int podd
  );
    return (div >= 2)
      && (dbits >= 5) && (dbits <= 9)
      && ((sbits == 1) || (sbits == 2))
      && ((podd == 0) || (podd == 1));
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word handshake bundle for uart_rx_os.
// master drives data/valid, slave returns ready.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Baud x16 tick divider with synchronous clear for frame alignment.
// Shared between the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] TOP = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = ~clr & (cnt == TOP);

  always_ff @(posedge clk) begin
    if (rst || clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority-vote bit decisions.
// Define UART_RX_PARITY_EN to expect and check a parity bit.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  uart_rx_os_if.master bus,
  output logic frame_err,
  output logic parity_err,
  output logic overrun,
  output logic busy
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  localparam logic SLAST = 1'(STOP_BITS - 1);

  if (!params_ok(DIV, DATA_BITS, STOP_BITS, PARITY_ODD))
  begin : g_bad_params
    $error("uart_rx_os: illegal parameters");
  end

  logic [1:0]           sync;
  logic                 rxs;
  logic                 rxs_q;
  rx_state_t            state;
  logic [OS_W-1:0]      os;
  logic [BW-1:0]        idx;
  logic                 sidx;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           smp;
  logic                 perr;
  logic                 tick;
  logic                 fall;
  logic                 clr;
  logic                 maj;
  logic                 dec;

  assign rxs  = sync[1];
  assign fall = rxs_q & ~rxs;
  assign clr  = (state == S_IDLE) & fall;
  assign dec  = tick & (os == OS_MID_HI);
  assign busy = (state != S_IDLE);
  assign maj  = (smp[0] & smp[1])
              | (smp[0] & rxs)
              | (smp[1] & rxs);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst)
      sync <= 2'b11;
    else
      sync <= {sync[0], rx};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)
      perr <= 1'b0;
    else if (state == S_PARITY && dec)
      perr <= ((^shreg) ^ maj) != (PARITY_ODD != 0);
  end
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      os           <= '0;
      idx          <= '0;
      sidx         <= 1'b0;
      shreg        <= '0;
      smp          <= '0;
      rxs_q        <= 1'b1;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rxs_q      <= rxs;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (bus.rx_valid && bus.rx_ready)
        bus.rx_valid <= 1'b0;
      if (tick && busy && state != S_WAIT_HIGH) begin
        os <= os + 1'b1;
        if (os == OS_MID_LO) smp[0] <= rxs;
        if (os == OS_MID)    smp[1] <= rxs;
      end
      unique case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            os    <= '0;
          end
        end
        S_START: begin
          if (dec) begin
            state <= maj ? S_IDLE : S_DATA;
            idx   <= '0;
          end
        end
        S_DATA: begin
          if (dec) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (idx == LAST) begin
              sidx <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (dec)
            state <= S_STOP;
        end
`endif
        S_STOP: begin
          if (dec) begin
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= S_WAIT_HIGH;
            end else if (sidx != SLAST) begin
              sidx <= 1'b1;
            end else begin
              state <= S_IDLE;
              if (perr)
                parity_err <= 1'b1;
              else if (!bus.rx_valid || bus.rx_ready) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
              end else
                overrun <= 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rxs)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised 16x-oversampling UART receiver: the next-generation receive front end for the DE2 serial designs. Converts the asynchronous `rx` line into data words and delivers them over a valid/ready handshake with a one-entry holding buffer. Supports configurable word length and stop bits, majority-vote bit sampling, and framing/overrun reporting, with optional parity checking. Sits between the board RS-232 pin and the command/LED logic.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `DATA_BITS`, 8, word length; legal range 5..9
- `STOP_BITS`, 1, number of stop bits checked; 1 or 2
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- `clk`  in  1  single system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous serial input; idles high
- `rx_data`  out  DATA_BITS  received word, LSB first on the line; reset 0
- `rx_valid`  out  1  `rx_data` holds an unconsumed word; reset 0
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; reset 0
- `parity_err`  out  1  one-cycle pulse: parity mismatch; tied 0 without parity; reset 0
- `overrun`  out  1  one-cycle pulse: word dropped because the buffer was full; reset 0
- `busy`  out  1  FSM not in IDLE; reset 0

## Operation
- `rx` passes through a 2-FF synchronizer (reset to 1). All decisions use the synchronized value `rxs`.
- Tick generator: `DIV = CLK_FREQ / (BAUD*16)`, integer truncation. A one-cycle `tick` occurs every DIV clocks. The counter is cleared on the start-bit edge, so tick phase is aligned to the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: a falling `rxs` (1 to 0) moves to START, clears the tick counter and clears the 4-bit oversample counter `os`.
- Per bit, samples are taken at `os` = 7, 8 and 9. The bit value is the majority of the three samples, decided at `os` = 9. The bit period ends at `os` = 15; `os` wraps to 0.
- START: a majority of 1 is a false start; return to IDLE with no error pulse. Otherwise go to DATA with bit index 0.
- DATA: shift the majority bit in LSB-first. After bit `DATA_BITS-1`, go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: compare XOR(data bits, sampled parity bit) against `PARITY_ODD`.
- STOP: check `STOP_BITS` stop bits.
  - Any stop bit with majority 0: pulse `frame_err`, discard the word, go to WAIT_HIGH.
  - All high and parity OK: commit the word, return to IDLE at the last stop bit's `os` = 9. The remaining half stop bit is not waited out.
  - Parity error: pulse `parity_err`, discard the word, return to IDLE.
- WAIT_HIGH: stay until `rxs` = 1. This covers a break condition. No further errors are reported while waiting.
- Commit rules:
  - Buffer empty, or `rx_ready` high in the same cycle: load `rx_data` and set `rx_valid`. No overrun.
  - Buffer full and `rx_ready` low: keep the old word and pulse `overrun`.
- Handshake: `rx_valid` clears on the cycle after `rx_valid && rx_ready` unless a commit occurs in that same cycle. `rx_data` is stable while `rx_valid` is high.
- Reset in mid-frame: all state returns to reset values and the partial word is lost. The next frame is detected only after `rxs` has been seen high and then falls.

## Timing
- Synchronizer latency: 2 clocks from `rx` to `rxs`.
- `rx_valid`, `frame_err`, `parity_err` and `overrun` are registered. They assert on the clock after the decision tick (`os` = 9 of the last stop bit, or of the failing bit).
- End-to-end: `rx_valid` asserts about (1 + DATA_BITS + P + 0.5 + (STOP_BITS−1)) × 16 × DIV + 3 clocks after the start-bit edge on `rx`, where P = 1 with parity and 0 without.
- Throughput: back-to-back frames with no idle gap are received when `rx_ready` is held high.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, parity register and `parity_err` logic are compiled in.
  - The frame carries one parity bit after the data bits.
- Not defined:
  - No parity bit is expected; the bit after the data is treated as the first stop bit.
  - `parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg`:
  - FSM state encoding.
  - Oversample constants: `OS_RATE` = 16, `OS_MID` = 7 / 8 / 9.
  - Parameter-check function asserting `DIV >= 2` and the legal `DATA_BITS` range.
- Sub-module `uart_baud_tick`: divider producing `tick`, with a synchronous clear input. It will be reused by the matching transmitter.

## Test plan
Bench parameters: CLK_FREQ = 1_600_000, BAUD = 10_000, giving DIV = 10 and 160 clocks per bit.
- Frame 0x5A, 8N1, `rx_ready` held high -> `rx_valid` one cycle with `rx_data` = 0x5A; no error pulses.
- 3-clock low glitch on idle `rx` -> return to IDLE; `rx_valid`, `frame_err` and `busy` fall with no output pulse.
- Frame 0xA5 with stop bit forced low, then `rx` held low for 2000 clocks -> one `frame_err` pulse, FSM stays in WAIT_HIGH, no `rx_valid`; next good frame 0x3C received.
- Two frames 0x11 then 0x22 with `rx_ready` low -> `rx_data` stays 0x11, one `overrun` pulse; raising `rx_ready` consumes 0x11 and `rx_valid` falls.
- With `UART_RX_PARITY_EN`, even parity: 0x07 with parity bit 1 -> `rx_valid`, data 0x07; the same frame with parity bit 0 -> `parity_err` pulse and no `rx_valid`.
- `rst` asserted at DATA bit 4 of frame 0xFF -> all outputs 0 the next cycle; the following frame 0x81 is received correctly.
